// File: rtl/gray_counter.sv
// gray_counter
//   Up/down counter holding a binary count and a registered Gray-coded copy,
//   both updated on the same clock edge. Supports synchronous load, wrap or
//   saturate behaviour at the limits, a one-cycle terminal-count pulse and a
//   sticky self-check error flag.
//
// Parameters
//   WIDTH     counter width, 1..32
//   WRAP      1 = wrap at the limits, 0 = saturate at the limits
//   RESET_VAL binary reset value (truncated to WIDTH)
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   ena       count enable, one step per cycle
//   dir       1 = up, 0 = down (used only when a step occurs)
//   load      synchronous load, has priority over ena
//   load_val  binary value to load
//   bin_out   registered binary count
//   gray_out  registered Gray count (bin_out ^ (bin_out >> 1))
//   tc        one-cycle pulse after a wrap or a blocked (saturated) step
//   err       sticky self-check failure, cleared only by rst
module gray_counter #(
  parameter int          WIDTH     = 8,
  parameter bit          WRAP      = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] RST_BIN = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB: bit i of the binary value is the XOR of all
  // Gray bits at positions >= i, i.e. the XOR of every right shift of g.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  // True when a and b differ in exactly one bit position.
  function automatic logic one_bit_diff(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - ONE)) == '0);
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] gray_prev_q;
  logic             tc_q, tc_d;
  logic             step_q, step_d;
  logic             err_q;
  logic             at_lim;
  logic [WIDTH-1:0] nxt;
  logic             chk_fail;

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;
  assign err      = err_q;

  always_comb begin
    bin_d  = bin_q;
    tc_d   = 1'b0;
    step_d = 1'b0;
    at_lim = 1'b0;
    nxt    = bin_q;
    if (load) begin
      bin_d = load_val;
    end else if (ena) begin
      if (dir) begin
        at_lim = (bin_q == MAX_VAL);
        nxt    = bin_q + ONE;
      end else begin
        at_lim = (bin_q == '0);
        nxt    = bin_q - ONE;
      end
      // Modulo arithmetic already produces the wrapped value; saturate mode
      // simply refuses the step at the limit.
      tc_d = at_lim;
      if (!at_lim || WRAP) begin
        bin_d  = nxt;
        step_d = 1'b1;
      end
    end
    // Gray is derived from the next binary value so both register together.
    gray_d = bin2gray(bin_d);

    // Checks look at the visible outputs: decode consistency every cycle and,
    // after an executed step, a single-bit Gray change versus the prior value.
    chk_fail = (gray2bin(gray_out) != bin_out) ||
               (step_q && !one_bit_diff(gray_prev_q, gray_out));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q       <= RST_BIN;
      gray_q      <= bin2gray(RST_BIN);
      gray_prev_q <= bin2gray(RST_BIN);
      tc_q        <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      gray_prev_q <= gray_out;
      tc_q        <= tc_d;
      step_q      <= step_d;
      err_q       <= err_q | chk_fail;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val4 = 4'd0;
  logic [7:0] load_val8 = 8'd0;

  logic [3:0] bin_w, gray_w, bin_s, gray_s;
  logic [7:0] bin_8, gray_8;
  logic [0:0] bin_1, gray_1;
  logic       tc_w, err_w, tc_s, err_s, tc_8, err_8, tc_1, err_1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(32'd5)) dut_w (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir), .load(load),
    .load_val(load_val4), .bin_out(bin_w), .gray_out(gray_w),
    .tc(tc_w), .err(err_w));

  gray_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(32'd3)) dut_s (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir), .load(load),
    .load_val(load_val4), .bin_out(bin_s), .gray_out(gray_s),
    .tc(tc_s), .err(err_s));

  gray_counter #(.WIDTH(8), .WRAP(1'b1), .RESET_VAL(32'd0)) dut_8 (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir), .load(load),
    .load_val(load_val8), .bin_out(bin_8), .gray_out(gray_8),
    .tc(tc_8), .err(err_8));

  gray_counter #(.WIDTH(1), .WRAP(1'b1), .RESET_VAL(32'd0)) dut_1 (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir), .load(load),
    .load_val(load_val4[0:0]), .bin_out(bin_1), .gray_out(gray_1),
    .tc(tc_1), .err(err_1));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] m8;
  logic [7:0] gtmp;

  initial begin
    // Reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_bin",  32'(bin_w),  32'd5);
    check("rst_gray", 32'(gray_w), 32'b0111);
    check("rst_tc",   32'(tc_w),   32'd0);
    check("rst_err",  32'(err_w),  32'd0);
    check("rst_sat_gray", 32'(gray_s), 32'b0010);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("hold_bin", 32'(bin_w), 32'd5);

    // Up wrap / saturate from 14.
    load = 1'b1; load_val4 = 4'd14;
    tick();
    check("ld14_bin",  32'(bin_w),  32'd14);
    check("ld14_gray", 32'(gray_w), 32'b1001);
    check("ld14_tc",   32'(tc_w),   32'd0);
    load = 1'b0; ena = 1'b1; dir = 1'b1;
    tick();
    check("up1_bin",  32'(bin_w),  32'd15);
    check("up1_gray", 32'(gray_w), 32'b1000);
    check("up1_tc",   32'(tc_w),   32'd0);
    check("sat1_bin", 32'(bin_s),  32'd15);
    check("sat1_tc",  32'(tc_s),   32'd0);
    check("w1_bin",   32'(bin_1),  32'd1);
    check("w1_gray",  32'(gray_1), 32'd1);
    tick();
    check("up2_bin",   32'(bin_w),  32'd0);
    check("up2_gray",  32'(gray_w), 32'b0000);
    check("up2_tc",    32'(tc_w),   32'd1);
    check("sat2_bin",  32'(bin_s),  32'd15);
    check("sat2_gray", 32'(gray_s), 32'b1000);
    check("sat2_tc",   32'(tc_s),   32'd1);
    check("w1_wrap_bin", 32'(bin_1), 32'd0);
    check("w1_wrap_tc",  32'(tc_1),  32'd1);
    tick();
    check("up3_bin",   32'(bin_w),  32'd1);
    check("up3_gray",  32'(gray_w), 32'b0001);
    check("up3_tc",    32'(tc_w),   32'd0);
    check("sat3_bin",  32'(bin_s),  32'd15);
    check("sat3_gray", 32'(gray_s), 32'b1000);
    check("sat3_tc",   32'(tc_s),   32'd1);
    check("up_err",    32'(err_w),  32'd0);
    ena = 1'b0;
    tick();
    check("hold_sat_tc", 32'(tc_s), 32'd0);
    check("hold_sat_bin", 32'(bin_s), 32'd15);

    // Down wrap / saturate from 1.
    load = 1'b1; load_val4 = 4'd1;
    tick();
    check("ld1_bin", 32'(bin_w), 32'd1);
    load = 1'b0; ena = 1'b1; dir = 1'b0;
    tick();
    check("dn1_bin", 32'(bin_w), 32'd0);
    check("dn1_tc",  32'(tc_w),  32'd0);
    tick();
    check("dn2_bin",  32'(bin_w),  32'd15);
    check("dn2_gray", 32'(gray_w), 32'b1000);
    check("dn2_tc",   32'(tc_w),   32'd1);
    check("sdn2_bin", 32'(bin_s),  32'd0);
    check("sdn2_tc",  32'(tc_s),   32'd1);
    tick();
    check("dn3_bin",  32'(bin_w),  32'd14);
    check("dn3_gray", 32'(gray_w), 32'b1001);
    check("dn3_tc",   32'(tc_w),   32'd0);
    check("sdn3_tc",  32'(tc_s),   32'd1);

    // Load beats ena; then async reset mid-count.
    load = 1'b1; load_val4 = 4'd9; dir = 1'b1;
    tick();
    check("pri_bin",  32'(bin_w),  32'd9);
    check("pri_gray", 32'(gray_w), 32'b1101);
    check("pri_tc",   32'(tc_w),   32'd0);
    load = 1'b0;
    tick();
    check("pri_step", 32'(bin_w), 32'd10);
    #2 rst = 1'b1;
    #1;
    check("arst_bin",  32'(bin_w),  32'd5);
    check("arst_gray", 32'(gray_w), 32'b0111);
    check("arst_sbin", 32'(bin_s),  32'd3);
    tick();
    check("arst_hold", 32'(bin_w), 32'd5);
    rst = 1'b0;
    tick();
    check("arst_resume", 32'(bin_w), 32'd6);

    // Random sweep on the 8-bit counter against a reference model.
    load = 1'b1; load_val8 = 8'd0; ena = 1'b0;
    tick();
    load = 1'b0;
    m8 = 8'd0;
    for (int i = 0; i < 600; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      tick();
      if (ena) m8 = dir ? m8 + 8'd1 : m8 - 8'd1;
      check("sw_bin",  32'(bin_8),  32'(m8));
      check("sw_gray", 32'(gray_8), 32'(m8 ^ (m8 >> 1)));
      check("sw_err",  32'(err_8),  32'd0);
    end

    // Corrupt one Gray bit: err sets on the next edge and stays set.
    ena = 1'b0;
    gtmp = gray_8 ^ 8'h01;
    force dut_8.gray_out = gtmp;
    tick();
    check("force_err", 32'(err_8), 32'd1);
    release dut_8.gray_out;
    tick();
    tick();
    check("err_sticky", 32'(err_8), 32'd1);
    check("err_other",  32'(err_w), 32'd0);
    rst = 1'b1;
    #1;
    check("err_clr", 32'(err_8), 32'd0);
    rst = 1'b0;
    tick();
    check("err_after_rst", 32'(err_8), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
